// File: rtl/fwd_operand_stage.sv
// ID/EX operand register with MEM/WB forwarding, one-cycle load-use bubble,
// back-pressure hold, flush and a saturating stall-cycle counter.
module fwd_operand_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NOPS = 2,
    parameter int SCW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [NOPS*AW-1:0] id_rs,
    input  logic [NOPS*DW-1:0] id_rdata,
    input  logic [AW-1:0]      id_rd,
    input  logic               id_we,
    input  logic               id_is_load,
    input  logic [AW-1:0]      mem_rd,
    input  logic               mem_we,
    input  logic               mem_is_load,
    input  logic [DW-1:0]      mem_data,
    input  logic [AW-1:0]      wb_rd,
    input  logic               wb_we,
    input  logic [DW-1:0]      wb_data,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [NOPS*DW-1:0] ex_op,
    output logic [NOPS*2-1:0]  ex_fsel,
    output logic [AW-1:0]      ex_rd,
    output logic               ex_we,
    output logic               ex_is_load,
    output logic [SCW-1:0]     stall_cnt
);

    logic               r_ex_valid;
    logic [AW-1:0]      r_ex_rd;
    logic               r_ex_we;
    logic               r_ex_is_load;
    logic [NOPS*AW-1:0] r_rs;
    logic [NOPS*DW-1:0] r_data;
    logic [SCW-1:0]     r_stall_cnt;

    logic               w_hz;
    logic [NOPS*DW-1:0] w_latch_data;
    logic [NOPS*DW-1:0] w_op;
    logic [NOPS*2-1:0]  w_fsel;

    always_comb begin
        w_hz         = 1'b0;
        w_latch_data = id_rdata;
        for (int unsigned i = 0; i < NOPS; i++) begin
            if (r_ex_valid && r_ex_is_load && r_ex_we && (r_ex_rd != '0) &&
                (r_ex_rd == id_rs[i*AW +: AW]))
                w_hz = 1'b1;
            // Write-through covers the register file write landing this same edge.
            if (wb_we && (wb_rd != '0) && (wb_rd == id_rs[i*AW +: AW]))
                w_latch_data[i*DW +: DW] = wb_data;
        end
    end

    always_comb begin
        w_op   = r_data;
        w_fsel = '0;
        for (int unsigned i = 0; i < NOPS; i++) begin
            if (r_ex_valid) begin
                if (mem_we && !mem_is_load && (mem_rd != '0) && (mem_rd == r_rs[i*AW +: AW])) begin
                    w_op[i*DW +: DW] = mem_data;
                    w_fsel[i*2 +: 2] = 2'b10;
                end else if (wb_we && (wb_rd != '0) && (wb_rd == r_rs[i*AW +: AW])) begin
                    w_op[i*DW +: DW] = wb_data;
                    w_fsel[i*2 +: 2] = 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_rs         <= '0;
            r_data       <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (!ex_ready) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hz) begin
            r_ex_valid <= 1'b0;
            r_ex_we    <= 1'b0;
            if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + SCW'(1);
        end else begin
            r_ex_valid   <= id_valid;
            r_ex_rd      <= id_rd;
            r_ex_we      <= id_we & id_valid;
            r_ex_is_load <= id_is_load;
            r_rs         <= id_rs;
            r_data       <= w_latch_data;
        end
    end

    assign id_ready   = flush | (ex_ready & ~w_hz);
    assign ex_valid   = r_ex_valid;
    assign ex_op      = w_op;
    assign ex_fsel    = w_fsel;
    assign ex_rd      = r_ex_rd;
    assign ex_we      = r_ex_we;
    assign ex_is_load = r_ex_is_load;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage: reset, forwarding priority, load-use,
// r0, back-pressure, flush, counter saturation (SCW=2 twin) and mid-stall reset.
module tb_fwd_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NOPS = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [NOPS*AW-1:0] id_rs;
    logic [NOPS*DW-1:0] id_rdata;
    logic [AW-1:0]     id_rd;
    logic              id_we;
    logic              id_is_load;
    logic [AW-1:0]     mem_rd;
    logic              mem_we;
    logic              mem_is_load;
    logic [DW-1:0]     mem_data;
    logic [AW-1:0]     wb_rd;
    logic              wb_we;
    logic [DW-1:0]     wb_data;
    logic              ex_ready;
    logic              ex_valid;
    logic [NOPS*DW-1:0] ex_op;
    logic [NOPS*2-1:0] ex_fsel;
    logic [AW-1:0]     ex_rd;
    logic              ex_we;
    logic              ex_is_load;
    logic [15:0]       stall_cnt;

    logic              s_id_ready;
    logic              s_ex_valid;
    logic [NOPS*DW-1:0] s_ex_op;
    logic [NOPS*2-1:0] s_ex_fsel;
    logic [AW-1:0]     s_ex_rd;
    logic              s_ex_we;
    logic              s_ex_is_load;
    logic [1:0]        s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_operand_stage #(.DW(DW), .AW(AW), .NOPS(NOPS), .SCW(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rdata(id_rdata), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_is_load(mem_is_load), .mem_data(mem_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_fsel(ex_fsel), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .stall_cnt(stall_cnt)
    );

    fwd_operand_stage #(.DW(DW), .AW(AW), .NOPS(NOPS), .SCW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(s_id_ready),
        .id_rs(id_rs), .id_rdata(id_rdata), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_is_load(mem_is_load), .mem_data(mem_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(s_ex_valid), .ex_op(s_ex_op),
        .ex_fsel(s_ex_fsel), .ex_rd(s_ex_rd), .ex_we(s_ex_we), .ex_is_load(s_ex_is_load),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [AW-1:0] rs1, input logic [AW-1:0] rs0,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d0,
                          input logic [AW-1:0] rd, input logic we, input logic ld);
        id_valid   = 1'b1;
        id_rs      = {rs1, rs0};
        id_rdata   = {d1, d0};
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
    endtask

    initial begin
        // Reset with every input active.
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_id(5'd2, 5'd1, 32'h22, 32'h11, 5'd9, 1'b1, 1'b1);
        mem_rd = 5'd7; mem_we = 1'b1; mem_is_load = 1'b0; mem_data = 32'hFFFF_0000;
        wb_rd = 5'd8; wb_we = 1'b1; wb_data = 32'h0000_FFFF;
        tick(); tick();
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_fsel", 64'(ex_fsel), 64'd0);
        check("rst_op", ex_op, 64'd0);
        check("rst_rd", 64'(ex_rd), 64'd0);

        rst_n = 1'b1; mem_we = 1'b0; wb_we = 1'b0;
        set_id(5'd2, 5'd1, 32'h22, 32'h11, 5'd0, 1'b0, 1'b0);
        tick();
        check("first_valid", 64'(ex_valid), 64'd1);
        check("first_op", ex_op, {32'h22, 32'h11});
        check("first_fsel", 64'(ex_fsel), 64'd0);

        // MEM beats WB; a MEM load falls through to WB.
        set_id(5'd4, 5'd3, 32'h44, 32'h33, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(5'd3, 5'd9, 32'h99, 32'h98, 5'd0, 1'b0, 1'b0);
        mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hBBBB;
        #1;
        check("mem_op", ex_op, {32'h44, 32'hAAAA});
        check("mem_fsel", 64'(ex_fsel), 64'b0010);
        mem_is_load = 1'b1;
        #1;
        check("wb_op0", 64'(ex_op[31:0]), 64'hBBBB);
        check("wb_fsel", 64'(ex_fsel), 64'b0001);
        tick();
        mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b0;
        #1;
        check("wthru_op", ex_op, {32'hBBBB, 32'h98});
        check("wthru_fsel", 64'(ex_fsel), 64'd0);

        // Load-use: load r5 in EX, consumer reads r5 on operand 1.
        set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(5'd5, 5'd6, 32'hDEAD, 32'h66, 5'd7, 1'b1, 1'b0);
        #1;
        check("lu_ready", 64'(id_ready), 64'd0);
        tick();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_stall", 64'(stall_cnt), 64'd1);
        check("lu_ready2", 64'(id_ready), 64'd1);
        mem_we = 1'b1; mem_rd = 5'd5; mem_is_load = 1'b1; mem_data = 32'hBAD0;
        tick();
        mem_we = 1'b0; mem_is_load = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        #1;
        check("lu_valid", 64'(ex_valid), 64'd1);
        check("lu_op", ex_op, {32'h1234, 32'h66});
        check("lu_fsel", 64'(ex_fsel), 64'b0100);
        check("lu_stall2", 64'(stall_cnt), 64'd1);
        wb_we = 1'b0;

        // r0 is never forwarded, and a load to r0 never stalls.
        set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF;
        tick();
        check("r0_op", ex_op, 64'd0);
        check("r0_fsel", 64'(ex_fsel), 64'd0);
        check("r0_ready", 64'(id_ready), 64'd1);
        tick();
        check("r0_valid", 64'(ex_valid), 64'd1);
        check("r0_stall", 64'(stall_cnt), 64'd1);
        mem_we = 1'b0;

        // Back-pressure holds EX for three cycles.
        set_id(5'd2, 5'd1, 32'h55, 32'h66, 5'd3, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        set_id(5'd8, 5'd9, 32'h77, 32'h88, 5'd4, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_op", ex_op, {32'h55, 32'h66});
            check("bp_rd", 64'(ex_rd), 64'd3);
            check("bp_ctrl", 64'({ex_valid, ex_we, ex_is_load, id_ready}), 64'b1100);
        end
        ex_ready = 1'b1;

        // Flush overrides a load-use hazard.
        set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1);
        tick();
        set_id(5'd10, 5'd0, 32'h1, 32'h2, 5'd11, 1'b1, 1'b0);
        #1;
        check("fl_hz", 64'(id_ready), 64'd0);
        flush = 1'b1;
        #1;
        check("fl_ready", 64'(id_ready), 64'd1);
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(ex_valid), 64'd0);
        check("fl_stall", 64'(stall_cnt), 64'd1);

        // Four more load-use events: wide counter reaches 5, SCW=2 twin pins at 3.
        for (int n = 2; n <= 5; n++) begin
            set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1);
            tick();
            set_id(5'd12, 5'd12, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0);
            tick();
            check("sat_bubble", 64'({ex_valid, s_ex_valid}), 64'b00);
            check("sat_wide", 64'(stall_cnt), 64'(n));
            check("sat_narrow", 64'(s_stall_cnt), (n > 3) ? 64'd3 : 64'(n));
            tick();
        end

        // Reset during a stall clears the hazard immediately.
        set_id(5'd0, 5'd0, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1);
        tick();
        set_id(5'd14, 5'd0, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0);
        #1;
        check("mr_hz", 64'(id_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mr_ready", 64'(id_ready), 64'd1);
        check("mr_valid", 64'(ex_valid), 64'd0);
        check("mr_stall", 64'({stall_cnt, s_stall_cnt}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
